// File: rtl/compressor_pkg.sv
// Shared constants and band-layout helpers for the 27:8 column compressor array.
package compressor_pkg;

  localparam int CMP_GROUP_IN  = 27;
  localparam int CMP_GROUP_OUT = 8;
  localparam int CMP_BANDS     = 4;

  function automatic int cmp_ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Band of a group output bit: bit0 -> 0, bits3:1 -> 1, bits6:4 -> 2, bit7 -> 3
  function automatic int cmp_bit_band(input int j);
    if (j == 0) return 0;
    else if (j <= 3) return 1;
    else if (j <= 6) return 2;
    else return 3;
  endfunction

  function automatic int cmp_band_lsb(input int b);
    case (b)
      0: return 0;
      1: return 1;
      2: return 4;
      default: return 7;
    endcase
  endfunction

  function automatic int cmp_band_bits(input int b);
    return (b == 0 || b == 3) ? 1 : 3;
  endfunction

  function automatic int cmp_band_off(input int b, input int g);
    return g * cmp_band_lsb(b);
  endfunction

  function automatic int cmp_band_width(input int b, input int g);
    return g * cmp_band_bits(b);
  endfunction

  // Band that a bit position of the regrouped output vector belongs to
  function automatic int cmp_out_band(input int j, input int g);
    if (j < cmp_band_off(1, g)) return 0;
    else if (j < cmp_band_off(2, g)) return 1;
    else if (j < cmp_band_off(3, g)) return 2;
    else return 3;
  endfunction

endpackage

// File: rtl/compressor_27_8.sv
// 27 equal-weight bits -> 8 bits with weights {8,4,4,4,2,2,2,1}; all-ones input gives 8'hFF.
module compressor_27_8
  import compressor_pkg::*;
(
  input  logic [CMP_GROUP_IN-1:0]  d,
  output logic [CMP_GROUP_OUT-1:0] o
);

  logic [4:0] cnt;
  logic [3:0] r, q, half, t1, t2;
  logic       b7;

  // Count in units of 2 after bit0, spend weight-8 first, then fill weight-4 before weight-2
  always_comb begin
    cnt = '0;
    for (int k = 0; k < CMP_GROUP_IN; k++) cnt = cnt + 5'(d[k]);
    r    = cnt[4:1];
    b7   = (r >= 4'd8);
    q    = b7 ? (r - 4'd4) : r;
    half = q >> 1;
    t2   = (half > 4'd3) ? 4'd3 : half;
    t1   = q - (t2 << 1);
    o    = {b7, (t2 >= 4'd3), (t2 >= 4'd2), (t2 >= 4'd1),
            (t1 >= 4'd3), (t1 >= 4'd2), (t1 >= 4'd1), cnt[0]};
  end

endmodule

// File: rtl/pipe_reg_stage.sv
// One valid/ready register slice; loads whenever empty or the consumer is taking the current entry.
module pipe_reg_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] d_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d_out
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d_out     <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) d_out <= d_in;
    end
  end

endmodule

// File: rtl/compressor_array_pipe.sv
// Pipelined array of compressor_27_8 with valid/ready flow control and weight-banded output.
// Macro COMPRESSOR_SUM_CHECK_EN adds a carried popcount compared against the weighted d_out sum (sum_err).
module compressor_array_pipe
  import compressor_pkg::*;
#(
  parameter int IN_BITS     = 513,
  parameter int PIPE_STAGES = 2,
  localparam int G          = cmp_ceil_div(IN_BITS, CMP_GROUP_IN),
  localparam int OUT_BITS   = CMP_GROUP_OUT * G
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  d_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] d_out,
  output logic                sum_err
);

  localparam int PAD_BITS = CMP_GROUP_IN * G;

`ifdef COMPRESSOR_SUM_CHECK_EN
  localparam int PW    = $clog2(PAD_BITS + 1);
  localparam int MID_W = OUT_BITS + PW;
  localparam int OUT_W = OUT_BITS + 1;
`else
  localparam int MID_W = OUT_BITS;
  localparam int OUT_W = OUT_BITS;
`endif

  logic [PAD_BITS-1:0] d_pad;
  logic [OUT_BITS-1:0] raw_c, raw_s, band_s;
  logic [MID_W-1:0]    mid_c, mid_s;
  logic [OUT_W-1:0]    out_c, out_q;
  logic                s_valid, s_ready;

  assign d_pad = PAD_BITS'(d_in);

  for (genvar i = 0; i < G; i++) begin : g_grp
    compressor_27_8 u_cmp (
      .d(d_pad[CMP_GROUP_IN*i +: CMP_GROUP_IN]),
      .o(raw_c[CMP_GROUP_OUT*i +: CMP_GROUP_OUT])
    );
  end

`ifdef COMPRESSOR_SUM_CHECK_EN
  logic [PW-1:0] pop_c, pop_s, wsum_s;
  logic          err_s, err_q;

  always_comb begin
    pop_c = '0;
    for (int k = 0; k < PAD_BITS; k++) pop_c = pop_c + PW'(d_pad[k]);
  end

  assign mid_c           = {pop_c, raw_c};
  assign {pop_s, raw_s}  = mid_s;
`else
  assign mid_c = raw_c;
  assign raw_s = mid_s;
`endif

  if (PIPE_STAGES >= 2) begin : g_mid
    pipe_reg_stage #(.W(MID_W)) u_mid (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .d_in(mid_c),
      .out_valid(s_valid), .out_ready(s_ready), .d_out(mid_s)
    );
  end else begin : g_bypass
    assign s_valid  = in_valid;
    assign in_ready = s_ready;
    assign mid_s    = mid_c;
  end

  // Group 0 lands in the most significant slice of every band
  always_comb begin
    band_s = '0;
    for (int i = 0; i < G; i++) begin
      for (int j = 0; j < CMP_GROUP_OUT; j++) begin
        band_s[cmp_band_off(cmp_bit_band(j), G)
               + cmp_band_bits(cmp_bit_band(j)) * (G - 1 - i)
               + (j - cmp_band_lsb(cmp_bit_band(j)))] = raw_s[CMP_GROUP_OUT*i + j];
      end
    end
  end

`ifdef COMPRESSOR_SUM_CHECK_EN
  always_comb begin
    wsum_s = '0;
    for (int j = 0; j < OUT_BITS; j++)
      if (band_s[j]) wsum_s = wsum_s + PW'(32'd1 << cmp_out_band(j, G));
  end

  assign err_s            = (wsum_s != pop_s);
  assign out_c            = {err_s, band_s};
  assign {err_q, d_out}   = out_q;
  assign sum_err          = out_valid & err_q;
`else
  assign out_c   = band_s;
  assign d_out   = out_q;
  assign sum_err = 1'b0;
`endif

  pipe_reg_stage #(.W(OUT_W)) u_out (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_valid), .in_ready(s_ready), .d_in(out_c),
    .out_valid(out_valid), .out_ready(out_ready), .d_out(out_q)
  );

endmodule

// File: tb/tb_compressor_array_pipe.sv
// Self-checking bench for compressor_array_pipe: three configurations against a per-group popcount model.
module tb_compressor_array_pipe;

  logic clk;
  logic rst_n;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sum_err;
  logic [512:0] a_d_in;
  logic [151:0] a_d_out;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sum_err;
  logic [27:0]  b_d_in;
  logic [15:0]  b_d_out;

  logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_sum_err;
  logic [39:0]  c_d_in;
  logic [15:0]  c_d_out;

  int n_checks;
  int n_errors;

  compressor_array_pipe #(.IN_BITS(513), .PIPE_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .d_in(a_d_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .d_out(a_d_out),
    .sum_err(a_sum_err)
  );

  compressor_array_pipe #(.IN_BITS(28), .PIPE_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .d_in(b_d_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .d_out(b_d_out),
    .sum_err(b_sum_err)
  );

  compressor_array_pipe #(.IN_BITS(40), .PIPE_STAGES(1)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .d_in(c_d_in),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .d_out(c_d_out),
    .sum_err(c_sum_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Random vector with selectable density: 0 ~ half, 1 ~ sparse, 2 ~ dense
  function automatic logic [543:0] rand_vec(input int mode);
    logic [543:0] v;
    v = '0;
    for (int w = 0; w < 17; w++) begin
      case (mode)
        0:       v[w*32 +: 32] = $urandom;
        1:       v[w*32 +: 32] = $urandom & $urandom & $urandom;
        default: v[w*32 +: 32] = $urandom | $urandom | $urandom;
      endcase
    end
    return v;
  endfunction

  // Weighted value of group i read back from the banded layout (group 0 is the top slice of each band)
  function automatic int group_weight(input logic [1023:0] dout, input int g, input int i);
    int s;
    s = g - 1 - i;
    return int'(dout[s])
         + 2 * (int'(dout[g + 3*s]) + int'(dout[g + 3*s + 1]) + int'(dout[g + 3*s + 2]))
         + 4 * (int'(dout[4*g + 3*s]) + int'(dout[4*g + 3*s + 1]) + int'(dout[4*g + 3*s + 2]))
         + 8 * int'(dout[7*g + s]);
  endfunction

  function automatic int group_bad(input logic [1023:0] dout, input logic [1023:0] din, input int in_bits);
    int g, bad, pc;
    g = (in_bits + 26) / 27;
    bad = 0;
    for (int i = 0; i < g; i++) begin
      pc = 0;
      for (int k = 27*i; k < 27*i + 27; k++)
        if (k < in_bits && din[k]) pc++;
      if (group_weight(dout, g, i) != pc) bad++;
    end
    return bad;
  endfunction

  function automatic int total_weight(input logic [1023:0] dout, input int g);
    int t;
    t = 0;
    for (int i = 0; i < g; i++) t += group_weight(dout, g, i);
    return t;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_d_out !== '0 || a_sum_err !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_a: out_valid=%b sum_err=%b d_out=%h, expected all zero", a_out_valid, a_sum_err, a_d_out);
    end
    n_checks++;
    if (b_out_valid !== 1'b0 || b_d_out !== '0 || c_out_valid !== 1'b0 || c_d_out !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_bc: b_valid=%b b_out=%h c_valid=%b c_out=%h, expected zeros", b_out_valid, b_d_out, c_out_valid, c_d_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL reset_ready: in_ready a=%b b=%b c=%b, expected 1", a_in_ready, b_in_ready, c_in_ready);
    end
  endtask

  task automatic test_all_ones();
    logic [151:0] exp_all;
    int tot;
    exp_all = '1;
    @(negedge clk);
    a_out_ready = 1'b1;
    a_d_in      = '1;
    a_in_valid  = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_d_in     = '0;
    #1;
    n_checks++;
    if (a_out_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL ones_early: out_valid=%b after one edge, expected 0", a_out_valid);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (a_out_valid !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL ones_latency: out_valid=%b after two edges, expected 1", a_out_valid);
    end
    n_checks++;
    if (a_d_out !== exp_all) begin
      n_errors++;
      $display("[TB] FAIL ones_dout: got %h expected %h", a_d_out, exp_all);
    end
    tot = total_weight(1024'(a_d_out), 19);
    n_checks++;
    if (tot != 513 || a_sum_err !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL ones_sum: weighted sum %0d sum_err %b, expected 513 and 0", tot, a_sum_err);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (a_out_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL ones_drain: out_valid=%b, expected 0 (single beat)", a_out_valid);
    end
  endtask

  task automatic test_padded_group();
    @(negedge clk);
    b_out_ready = 1'b1;
    b_d_in      = 28'h8000000;
    b_in_valid  = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    b_d_in     = '0;
    @(negedge clk);
    #1;
    n_checks++;
    if (b_out_valid !== 1'b1 || b_d_out !== 16'h0001) begin
      n_errors++;
      $display("[TB] FAIL padded_dout: valid=%b d_out=%h, expected 1 and 0001", b_out_valid, b_d_out);
    end
    n_checks++;
    if (total_weight(1024'(b_d_out), 2) != 1) begin
      n_errors++;
      $display("[TB] FAIL padded_sum: weighted sum %0d expected 1", total_weight(1024'(b_d_out), 2));
    end
    @(negedge clk);
  endtask

  task automatic test_single_stage();
    @(negedge clk);
    c_out_ready = 1'b1;
    c_d_in      = '0;
    c_in_valid  = 1'b1;
    #1;
    n_checks++;
    if (c_out_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL pipe1_idle: out_valid=%b expected 0", c_out_valid);
    end
    @(negedge clk);
    c_d_in = 40'h1;
    #1;
    n_checks++;
    if (c_out_valid !== 1'b1 || c_d_out !== 16'h0000) begin
      n_errors++;
      $display("[TB] FAIL pipe1_zero: valid=%b d_out=%h, expected 1 and 0000", c_out_valid, c_d_out);
    end
    @(negedge clk);
    c_in_valid = 1'b0;
    #1;
    n_checks++;
    if (c_out_valid !== 1'b1 || c_d_out !== 16'h0002) begin
      n_errors++;
      $display("[TB] FAIL pipe1_one: valid=%b d_out=%h, expected 1 and 0002", c_out_valid, c_d_out);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (c_out_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL pipe1_drain: out_valid=%b expected 0", c_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [512:0] items [10];
    logic [512:0] exp_q [$];
    logic [512:0] front;
    logic [151:0] held;
    logic         was_stalled;
    int sent, got, occ, bad;
    bit fire_in, fire_out;
    for (int n = 0; n < 10; n++) items[n] = 513'(rand_vec(n % 3));
    sent = 0; got = 0; occ = 0; was_stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      @(negedge clk);
      a_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      a_in_valid  = (sent < 10);
      a_d_in      = (sent < 10) ? items[sent] : '0;
      #1;
      n_checks++;
      if (a_in_ready !== ((occ < 2) || a_out_ready)) begin
        n_errors++;
        $display("[TB] FAIL stream_in_ready: cycle %0d got %b expected %b (occupancy %0d)", cyc, a_in_ready, (occ < 2) || a_out_ready, occ);
      end
      if (was_stalled) begin
        n_checks++;
        if (a_out_valid !== 1'b1 || a_d_out !== held) begin
          n_errors++;
          $display("[TB] FAIL stream_hold: cycle %0d valid=%b d_out=%h, expected 1 and %h", cyc, a_out_valid, a_d_out, held);
        end
      end
      fire_in  = a_in_valid && a_in_ready;
      fire_out = a_out_valid && a_out_ready;
      if (fire_out) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("[TB] FAIL stream_extra: unexpected output %h, expected none", a_d_out);
        end else begin
          front = exp_q.pop_front();
          bad = group_bad(1024'(a_d_out), 1024'(front), 513);
          if (bad != 0) begin
            n_errors++;
            $display("[TB] FAIL stream_data: beat %0d has %0d bad groups, expected 0 (d_out %h)", got, bad, a_d_out);
          end
        end
        n_checks++;
        if (a_sum_err !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL stream_sum_err: beat %0d got %b expected 0", got, a_sum_err);
        end
        got++;
      end
      was_stalled = a_out_valid && !a_out_ready;
      held        = a_d_out;
      if (fire_in) begin
        exp_q.push_back(items[sent]);
        sent++;
        occ++;
      end
      if (fire_out) occ--;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    n_checks++;
    if (got != 10) begin
      n_errors++;
      $display("[TB] FAIL stream_count: received %0d beats, expected 10", got);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    a_out_ready = 1'b0;
    a_d_in      = 513'(rand_vec(0));
    a_in_valid  = 1'b1;
    @(negedge clk);
    a_d_in = 513'(rand_vec(2));
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL mid_full: in_ready=%b out_valid=%b, expected 0 and 1", a_in_ready, a_out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_d_out !== '0 || a_sum_err !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL mid_async: out_valid=%b d_out=%h sum_err=%b, expected zeros", a_out_valid, a_d_out, a_sum_err);
    end
    #1 rst_n = 1'b1;
    a_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
        n_errors++;
        $display("[TB] FAIL mid_stale: cycle %0d out_valid=%b in_ready=%b, expected 0 and 1", k, a_out_valid, a_in_ready);
      end
    end
  endtask

  task automatic test_sum_check();
    logic [512:0] beats [3];
    int got;
    bit exp_err;
    beats[0] = 513'(rand_vec(0));
    beats[1] = '0;
    beats[2] = 513'(rand_vec(1));
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      @(negedge clk);
`ifdef COMPRESSOR_SUM_CHECK_EN
      release dut_a.raw_c;
      if (cyc == 1) force dut_a.raw_c = 152'h1;
`endif
      a_out_ready = 1'b1;
      a_in_valid  = (cyc < 3);
      a_d_in      = (cyc < 3) ? beats[cyc] : '0;
      #1;
      if (a_out_valid) begin
        exp_err = 1'b0;
`ifdef COMPRESSOR_SUM_CHECK_EN
        exp_err = (got == 1);
`endif
        n_checks++;
        if (a_sum_err !== exp_err) begin
          n_errors++;
          $display("[TB] FAIL sum_err_beat: beat %0d got %b expected %b", got, a_sum_err, exp_err);
        end
        got++;
      end
    end
`ifdef COMPRESSOR_SUM_CHECK_EN
    release dut_a.raw_c;
`endif
    a_in_valid = 1'b0;
    n_checks++;
    if (got != 3) begin
      n_errors++;
      $display("[TB] FAIL sum_count: received %0d beats, expected 3", got);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_d_in = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_d_in = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b0; c_d_in = '0;
    test_reset();
    test_all_ones();
    test_padded_group();
    test_single_stage();
    test_back_to_back();
    test_reset_midflight();
    test_sum_check();
    n_checks++;
    if (b_sum_err !== 1'b0 || c_sum_err !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL idle_sum_err: b=%b c=%b expected 0", b_sum_err, c_sum_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
